playbus2_sequencer: RTL and testbench

PLAYBUS2_SEQUENCER -- requirements
Module: playbus2_sequencer

---
 rtl/playbus2_sequencer.sv | 93 +++++++++
 tb/tb_playbus2_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/playbus2_sequencer.sv
// playbus2_sequencer: switch/LED/RAM/ROM bus sequencer with IDLE-EXEC-DONE control.
// Define PLAYBUS_CLASH_EN to turn function 7 into a bus contention demonstration.
module playbus2_sequencer #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] sw_data,
    input  logic [AW-1:0] sw_addr,
    input  logic [2:0]    sw_func,
    input  logic          go,
    output logic [DW-1:0] ledout,
    output logic [DW-1:0] bus,
    output logic          bus_z,
    output logic          contend,
    output logic [AW-1:0] address,
    output logic [2:0]    func,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state_q;
    logic [DW-1:0] ledout_q;
    logic [AW-1:0] address_q, address_d;
    logic [2:0] func_q;
    logic [DW-1:0] ram [2**AW];
    logic exec, blk, last, src_sw, src_ram, src_rom, clash, ram_we, led_we;
    logic [DW-1:0] rom_word;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        int v;
        v = 3 * int'(a) + 1;
        return v[DW-1:0];
    endfunction

    always_comb begin
        exec = state_q == EXEC;
        blk = func_q == 3'd5 || func_q == 3'd6;
        last = !blk || &address_q;
        address_d = blk ? address_q + AW'(1) : address_q;
        src_sw = exec && (func_q == 3'd1 || func_q == 3'd2);
        src_ram = exec && (func_q == 3'd3 || func_q == 3'd6);
        src_rom = exec && (func_q == 3'd4 || func_q == 3'd5);
`ifdef PLAYBUS_CLASH_EN
        clash = exec && func_q == 3'd7;
`else
        clash = 1'b0;
`endif
        rom_word = rom_f(address_q);
        // Wired-OR model of the shared bus; an undriven bus reads as 0.
        bus = ((src_sw || clash) ? sw_data : '0) | (src_ram ? ram[address_q] : '0)
            | ((src_rom || clash) ? rom_word : '0);
        bus_z = !(src_sw || src_ram || src_rom || clash);
        ram_we = exec && (func_q == 3'd2 || func_q == 3'd5);
        led_we = exec && (func_q == 3'd1 || func_q == 3'd3 || func_q == 3'd4 || func_q == 3'd6);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ledout_q <= '0;
            address_q <= '0;
            func_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    state_q <= EXEC;
                    address_q <= sw_addr;
                    func_q <= sw_func;
                end
                EXEC: begin
                    if (led_we) ledout_q <= bus;
                    address_q <= address_d;
                    if (last) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[address_q] <= bus;
    end

    assign contend = clash;
    assign ledout = ledout_q;
    assign address = address_q;
    assign func = func_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
endmodule

// File: tb/tb_playbus2_sequencer.sv
// tb_playbus2_sequencer: directed vectors with a done-driven scoreboard monitor.
module tb_playbus2_sequencer;
    logic clk = 0, reset = 0, go = 0;
    logic [3:0] sw_data = 0;
    logic [2:0] sw_addr = 0, sw_func = 0;
    logic [3:0] ledout, bus;
    logic bus_z, contend, busy, done;
    logic [2:0] address, func;
    int errors = 0, checks = 0;

    typedef struct {string nm; logic [3:0] led; logic [2:0] addr; logic [2:0] f;} exp_t;
    exp_t sb[$];
    logic [3:0] tb_bus[$], tb_led[$];
    logic tb_z[$], tb_c[$];

    always #5 clk = ~clk;

    playbus2_sequencer #(.DW(4), .AW(3)) dut (
        .clk(clk), .reset(reset), .sw_data(sw_data), .sw_addr(sw_addr), .sw_func(sw_func),
        .go(go), .ledout(ledout), .bus(bus), .bus_z(bus_z), .contend(contend),
        .address(address), .func(func), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sb.size() == 0) chk("spurious done", done, 0);
                else begin
                    e = sb.pop_front();
                    chk({e.nm, " ledout"}, ledout, e.led);
                    chk({e.nm, " address"}, address, e.addr);
                    chk({e.nm, " func"}, func, e.f);
                end
            end
        end
    endtask

    task automatic op(input logic [2:0] f, input logic [2:0] a, input logic [3:0] d,
                      input int nexec, input logic [3:0] led, input logic [2:0] addr,
                      input logic [3:0] bus0, input logic z0, input string nm);
        int nb = 0, nd = 0;
        sb.push_back('{nm, led, addr, f});
        tb_bus.delete(); tb_led.delete(); tb_z.delete(); tb_c.delete();
        @(negedge clk); sw_func = f; sw_addr = a; sw_data = d; go = 1;
        @(negedge clk); go = 0;
        while (busy && nb < 40) begin
            nb++;
            if (done) nd++;
            else begin
                tb_bus.push_back(bus); tb_z.push_back(bus_z); tb_c.push_back(contend);
            end
            tb_led.push_back(ledout);
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, nb, nexec + 1);
        chk({nm, " done pulses"}, nd, 1);
        chk({nm, " exec bus"}, tb_bus[0], bus0);
        chk({nm, " exec bus_z"}, tb_z[0], z0);
    endtask

    initial begin
        int nd;
        fork monitor(); join_none
        #2 reset = 1;
        #1;
        chk("reset ledout", ledout, 0);
        chk("reset address", address, 0);
        chk("reset busy", busy, 0);
        chk("reset bus_z", bus_z, 1);
        chk("reset bus", bus, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        op(2, 3, 9, 1, 0, 3, 9, 0, "sw2ram");
        op(3, 3, 0, 1, 9, 3, 9, 0, "ram2led");
        op(4, 2, 0, 1, 7, 2, 7, 0, "rom2led");
        op(5, 5, 0, 3, 7, 0, 0, 0, "copy");
        chk("copy bus1", tb_bus[1], 3);
        chk("copy bus2", tb_bus[2], 6);
        op(6, 6, 0, 2, 6, 0, 3, 0, "scan");
        chk("scan led1", tb_led[1], 3);
        chk("scan led2", tb_led[2], 6);
        op(3, 5, 0, 1, 0, 5, 0, 0, "ram5");
        op(1, 0, 5, 1, 5, 0, 5, 0, "sw2led");
        op(0, 4, 4'hF, 1, 5, 4, 0, 1, "nop");
        op(2, 2, 4'hA, 1, 5, 2, 4'hA, 0, "wr2");
        op(2, 1, 4'hC, 1, 5, 1, 4'hC, 0, "wr1");
`ifdef PLAYBUS_CLASH_EN
        op(7, 1, 4, 1, 5, 1, 4, 0, "clash");
        chk("clash contend", tb_c[0], 1);
`else
        op(7, 1, 4, 1, 5, 1, 0, 1, "clash");
        chk("clash contend", tb_c[0], 0);
`endif
        // Abort a block copy during its second EXEC cycle.
        @(negedge clk); sw_func = 5; sw_addr = 0; go = 1;
        @(negedge clk); go = 0;
        @(negedge clk);
        chk("abort pre address", address, 1);
        reset = 1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort address", address, 0);
        chk("abort ledout", ledout, 0);
        chk("abort bus_z", bus_z, 1);
        chk("abort done", done, 0);
        @(negedge clk); reset = 0;
        op(3, 0, 0, 1, 1, 0, 1, 0, "ram0");
        op(3, 1, 0, 1, 4'hC, 1, 4'hC, 0, "ram1");
        op(3, 2, 0, 1, 4'hA, 2, 4'hA, 0, "ram2");
        // go held high restarts after each DONE.
        sb.push_back('{"hold", 4'h3, 3'd4, 3'd1});
        sb.push_back('{"hold", 4'h3, 3'd4, 3'd1});
        @(negedge clk); sw_func = 1; sw_addr = 4; sw_data = 3; go = 1;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) nd++;
        end
        go = 0;
        chk("hold done pulses", nd, 2);
        @(negedge clk);
        chk("hold idle", busy, 0);
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
